depipe_flex: RTL and testbench
==============================

DEPIPE_FLEX -- requirements
Module: depipe_flex

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register-operand width (regA, regB).
REQ-002 The block SHALL have parameter INM_W, default 19, meaning immediate width.
REQ-003 The block SHALL have parameter IDX_W, default 4, meaning destination-register index width (regScr).
REQ-004 The block SHALL have parameter CTRL_W, default 4, meaning ALU control width (ALUctrl).
REQ-005 The block SHALL have parameter STAGES, default 1, legal range 1..4, meaning number of register stages between D and E.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port stall_E, input, 1 bit, meaning hold all stages.
REQ-009 The block SHALL have port flush_E, input, 1 bit, meaning replace all stages with bubbles.
REQ-010 The block SHALL have port valid_D, input, 1 bit, meaning the D-side bundle is a real instruction.
REQ-011 The block SHALL have ports regw_D, memw_D, regmem_D, branch_D, ALUope_D and flag_D, each input, 1 bit, the decode control bits.
REQ-012 The block SHALL have ports ALUctrl_D (input, CTRL_W), regScr_D (input, IDX_W), regA_D and regB_D (input, DATA_W each) and inm_D (input, INM_W).
REQ-013 The block SHALL have output ports valid_E, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E, ALUctrl_E, regScr_E, regA_E, regB_E and inm_E, each the same width as its _D counterpart.
REQ-014 The block SHALL have port flush_cnt, output, 16 bits, counting flushed valid instructions.
REQ-015 The block SHALL have port stall_cnt, output, 16 bits, counting stalled cycles.

Function
REQ-016 The block SHALL implement a chain of STAGES identical stage registers, each holding valid and the full bundle; stage 0 loads from the _D inputs and the _E outputs SHALL be driven directly from the last stage (no combinational path from _D to _E).
REQ-017 With stall_E=0 and flush_E=0, a bundle sampled at edge N SHALL appear on the _E outputs after edge N+STAGES-1, i.e. a latency of STAGES cycles.
REQ-018 On an edge where flush_E=1, every stage SHALL load a bubble: valid=0 and all control, index, data and immediate fields 0.
REQ-019 flush_E SHALL take priority over stall_E when both are 1 on the same edge.
REQ-020 On an edge where stall_E=1 and flush_E=0, every stage SHALL hold its contents and the _D inputs SHALL be ignored.
REQ-021 When valid_D=0 and the stage is not stalled, stage 0 SHALL load a bubble regardless of the other _D values.
REQ-022 While the last stage has valid=0, the control outputs regw_E, memw_E, regmem_E, branch_E and flag_E SHALL be 0, so no architectural side effects occur.
REQ-023 flush_cnt SHALL increment by the number of stages holding valid=1 on each flush edge, and SHALL saturate at 16'hFFFF.
REQ-024 stall_cnt SHALL increment by 1 on each edge with stall_E=1 and flush_E=0, and SHALL saturate at 16'hFFFF.
REQ-025 Widths SHALL be carried exactly; no sign or zero extension of inm SHALL occur inside the block.

Reset
REQ-026 While rst=0, all stages and both counters SHALL clear to 0 immediately, independent of clk, and every output SHALL read 0 (valid_E=0).
REQ-027 An assertion of rst mid-stall or mid-flush SHALL discard all in-flight bundles.
REQ-028 On the first edge after rst rises, the block SHALL operate normally from an empty pipeline.

Verification
REQ-029 Scenario: STAGES=1, valid_D=1, regw_D=1, ALUctrl_D=4'b0101, regScr_D=4'b0011, regA_D=32'h0000FFFF, regB_D=32'h00000801 -> one edge later the _E outputs carry the same values and valid_E=1.
REQ-030 Scenario: STAGES=3, three consecutive valid bundles with inm_D = 19'h00401, 19'h00402, 19'h00403 -> inm_E shows them in order, starting 3 cycles after the first.
REQ-031 Scenario: STAGES=3 with the pipeline full, flush_E=1 for one edge -> valid_E=0, all outputs 0 and flush_cnt=3 on the next cycle.
REQ-032 Scenario: stall_E=1 for 5 edges while ALUope_D and regA_D toggle -> outputs stay frozen and stall_cnt=5; on release, the bundle that was held in the pipeline emerges.
REQ-033 Scenario: stall_E=1 and flush_E=1 on the same edge -> bubble loaded and stall_cnt unchanged.
REQ-034 Scenario: rst=0 asserted between clock edges with valid data in flight -> all outputs 0 before the next edge; counters preloaded to 16'hFFFE then two flushes -> flush_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/depipe_flex_if.sv
// depipe_flex_if -- decode-to-execute bundle bus for depipe_flex.
//
// Carries the decode-side bundle (_D), the execute-side bundle (_E), the
// pipeline controls (stall_E, flush_E) and the two event counters.
//   master : driven by the decode/hazard side, observes _E and counters
//   slave  : the pipeline register block itself
interface depipe_flex_if #(
   parameter int DATA_W = 32,
   parameter int INM_W  = 19,
   parameter int IDX_W  = 4,
   parameter int CTRL_W = 4
);
   // pipeline controls
   logic              stall_E;
   logic              flush_E;
   // decode-side bundle
   logic              valid_D;
   logic              regw_D;
   logic              memw_D;
   logic              regmem_D;
   logic              branch_D;
   logic              ALUope_D;
   logic              flag_D;
   logic [CTRL_W-1:0] ALUctrl_D;
   logic [IDX_W-1:0]  regScr_D;
   logic [DATA_W-1:0] regA_D;
   logic [DATA_W-1:0] regB_D;
   logic [INM_W-1:0]  inm_D;
   // execute-side bundle
   logic              valid_E;
   logic              regw_E;
   logic              memw_E;
   logic              regmem_E;
   logic              branch_E;
   logic              ALUope_E;
   logic              flag_E;
   logic [CTRL_W-1:0] ALUctrl_E;
   logic [IDX_W-1:0]  regScr_E;
   logic [DATA_W-1:0] regA_E;
   logic [DATA_W-1:0] regB_E;
   logic [INM_W-1:0]  inm_E;
   // event counters
   logic [15:0]       flush_cnt;
   logic [15:0]       stall_cnt;

   modport master (
      output stall_E, flush_E,
      output valid_D, regw_D, memw_D, regmem_D, branch_D, ALUope_D, flag_D,
      output ALUctrl_D, regScr_D, regA_D, regB_D, inm_D,
      input  valid_E, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E,
      input  ALUctrl_E, regScr_E, regA_E, regB_E, inm_E,
      input  flush_cnt, stall_cnt
   );

   modport slave (
      input  stall_E, flush_E,
      input  valid_D, regw_D, memw_D, regmem_D, branch_D, ALUope_D, flag_D,
      input  ALUctrl_D, regScr_D, regA_D, regB_D, inm_D,
      output valid_E, regw_E, memw_E, regmem_E, branch_E, ALUope_E, flag_E,
      output ALUctrl_E, regScr_E, regA_E, regB_E, inm_E,
      output flush_cnt, stall_cnt
   );
endinterface

// File: rtl/depipe_flex.sv
// depipe_flex -- configurable-depth D->E pipeline register with stall/flush.
//
// A chain of STAGES (1..4) identical registers, each holding a valid bit and
// the full decode bundle. Stage 0 loads from the _D side; the _E side is
// driven straight from the last stage, so latency is STAGES cycles and there
// is no combinational D->E path.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset, clears stages and counters
//   bus  : depipe_flex_if.slave -- stall_E/flush_E, _D in, _E out,
//          flush_cnt (valid instructions killed by flushes, saturating),
//          stall_cnt (stalled cycles, saturating)
// The interface instance must use the same width parameters as this module.
module depipe_flex #(
   parameter int DATA_W = 32,
   parameter int INM_W  = 19,
   parameter int IDX_W  = 4,
   parameter int CTRL_W = 4,
   parameter int STAGES = 1   // legal range 1..4
) (
   input  logic          clk,
   input  logic          rst,
   depipe_flex_if.slave  bus
);

   typedef struct packed {
      logic              valid;
      logic              regw;
      logic              memw;
      logic              regmem;
      logic              branch;
      logic              aluope;
      logic              flag;
      logic [CTRL_W-1:0] aluctrl;
      logic [IDX_W-1:0]  regscr;
      logic [DATA_W-1:0] rega;
      logic [DATA_W-1:0] regb;
      logic [INM_W-1:0]  inm;
   } bundle_t;

   bundle_t     stage_q [STAGES];
   bundle_t     d_bundle;
   bundle_t     last;
   logic [2:0]  n_valid;      // up to 4 valid stages
   logic [16:0] flush_sum;    // one extra bit to detect overflow
   logic [15:0] flush_cnt_q;
   logic [15:0] stall_cnt_q;

   // An invalid decode slot becomes an all-zero bubble, so downstream never
   // sees stale control bits from a non-instruction.
   always_comb begin
      // NOTE: every always_comb output gets a default first; a path that
      // leaves it unassigned would infer a latch.
      d_bundle = '0;
      if (bus.valid_D) begin
         d_bundle.valid   = 1'b1;
         d_bundle.regw    = bus.regw_D;
         d_bundle.memw    = bus.memw_D;
         d_bundle.regmem  = bus.regmem_D;
         d_bundle.branch  = bus.branch_D;
         d_bundle.aluope  = bus.ALUope_D;
         d_bundle.flag    = bus.flag_D;
         d_bundle.aluctrl = bus.ALUctrl_D;
         d_bundle.regscr  = bus.regScr_D;
         d_bundle.rega    = bus.regA_D;
         d_bundle.regb    = bus.regB_D;
         d_bundle.inm     = bus.inm_D;
      end
   end

   // Number of live instructions that a flush on this edge would kill.
   always_comb begin
      n_valid = '0;
      for (int i = 0; i < STAGES; i++) begin
         n_valid = n_valid + 3'(stage_q[i].valid);
      end
   end

   assign flush_sum = {1'b0, flush_cnt_q} + 17'(n_valid);

   // Flush beats stall: a flush edge empties the chain even while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the stage array is a handful of flops, not a RAM, so it is
         // reset like any other state; real memories are left unreset.
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else if (bus.flush_E) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else if (!bus.stall_E) begin
         // NOTE: non-blocking assignments let every stage sample its
         // predecessor's old value on the same edge, giving a true shift.
         stage_q[0] <= d_bundle;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else if (bus.flush_E) begin
         flush_cnt_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
      end else if (bus.stall_E) begin
         if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   // Bubbles are all-zero, so an invalid last stage already presents zero
   // control bits without extra gating on the output.
   assign last          = stage_q[STAGES-1];
   assign bus.valid_E   = last.valid;
   assign bus.regw_E    = last.regw;
   assign bus.memw_E    = last.memw;
   assign bus.regmem_E  = last.regmem;
   assign bus.branch_E  = last.branch;
   assign bus.ALUope_E  = last.aluope;
   assign bus.flag_E    = last.flag;
   assign bus.ALUctrl_E = last.aluctrl;
   assign bus.regScr_E  = last.regscr;
   assign bus.regA_E    = last.rega;
   assign bus.regB_E    = last.regb;
   assign bus.inm_E     = last.inm;
   assign bus.flush_cnt = flush_cnt_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_depipe_flex.sv
// tb_depipe_flex -- directed self-checking bench for depipe_flex.
// Two instances: dut1 (STAGES=1) and dut3 (STAGES=3), driven one at a time.
module tb_depipe_flex;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   depipe_flex_if b1 ();
   depipe_flex_if b3 ();

   depipe_flex #(.STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   depipe_flex #(.STAGES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // advance one edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      {b1.stall_E, b1.flush_E, b1.valid_D, b1.regw_D, b1.memw_D, b1.regmem_D,
       b1.branch_D, b1.ALUope_D, b1.flag_D} = '0;
      b1.ALUctrl_D = '0; b1.regScr_D = '0; b1.regA_D = '0; b1.regB_D = '0; b1.inm_D = '0;
      {b3.stall_E, b3.flush_E, b3.valid_D, b3.regw_D, b3.memw_D, b3.regmem_D,
       b3.branch_D, b3.ALUope_D, b3.flag_D} = '0;
      b3.ALUctrl_D = '0; b3.regScr_D = '0; b3.regA_D = '0; b3.regB_D = '0; b3.inm_D = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b0;
      clear_inputs();

      // ---- reset state ----
      #12;
      check("rst_valid1",  b1.valid_E,   1'b0);
      check("rst_regA1",   b1.regA_E,    32'h0);
      check("rst_valid3",  b3.valid_E,   1'b0);
      check("rst_fcnt3",   b3.flush_cnt, 16'h0);
      check("rst_scnt3",   b3.stall_cnt, 16'h0);
      @(negedge clk);
      rst = 1'b1;
      step();

      // ---- STAGES=1 single bundle, one-cycle latency ----
      b1.valid_D = 1'b1; b1.regw_D = 1'b1; b1.ALUctrl_D = 4'b0101; b1.regScr_D = 4'b0011;
      b1.regA_D = 32'h0000FFFF; b1.regB_D = 32'h00000801; b1.inm_D = 19'h7FFFF;
      step();
      check("s1_valid",   b1.valid_E,   1'b1);
      check("s1_regw",    b1.regw_E,    1'b1);
      check("s1_memw",    b1.memw_E,    1'b0);
      check("s1_aluctrl", b1.ALUctrl_E, 4'b0101);
      check("s1_regscr",  b1.regScr_E,  4'b0011);
      check("s1_regA",    b1.regA_E,    32'h0000FFFF);
      check("s1_regB",    b1.regB_E,    32'h00000801);
      check("s1_inm",     b1.inm_E,     19'h7FFFF);
      // invalid slot with junk fields becomes a bubble
      b1.valid_D = 1'b0; b1.memw_D = 1'b1; b1.flag_D = 1'b1;
      step();
      check("s1_bub_valid", b1.valid_E,   1'b0);
      check("s1_bub_regw",  b1.regw_E,    1'b0);
      check("s1_bub_memw",  b1.memw_E,    1'b0);
      check("s1_bub_flag",  b1.flag_E,    1'b0);
      check("s1_bub_regA",  b1.regA_E,    32'h0);
      check("s1_bub_ctrl",  b1.ALUctrl_E, 4'h0);
      b1.memw_D = 1'b0; b1.flag_D = 1'b0;

      // ---- STAGES=3 ordered stream, three-cycle latency ----
      b3.regw_D = 1'b1; b3.regA_D = 32'h12340000; b3.valid_D = 1'b1;
      b3.inm_D = 19'h00401; step();
      check("s3_lat1", b3.valid_E, 1'b0);
      b3.inm_D = 19'h00402; step();
      check("s3_lat2", b3.valid_E, 1'b0);
      b3.inm_D = 19'h00403; step();
      check("s3_inm1",   b3.inm_E,   19'h00401);
      check("s3_valid1", b3.valid_E, 1'b1);
      b3.inm_D = 19'h00404; step();
      check("s3_inm2", b3.inm_E, 19'h00402);
      b3.inm_D = 19'h00405; step();
      check("s3_inm3", b3.inm_E, 19'h00403);

      // ---- flush of a full pipeline ----
      b3.flush_E = 1'b1; step();
      b3.flush_E = 1'b0; b3.valid_D = 1'b0;
      check("fl_valid", b3.valid_E,   1'b0);
      check("fl_inm",   b3.inm_E,     19'h0);
      check("fl_regw",  b3.regw_E,    1'b0);
      check("fl_regA",  b3.regA_E,    32'h0);
      check("fl_cnt",   b3.flush_cnt, 16'd3);
      step();
      check("fl_drain", b3.valid_E, 1'b0);

      // ---- stall for five edges with toggling inputs ----
      b3.valid_D = 1'b1; b3.ALUope_D = 1'b1; b3.inm_D = '0;
      b3.regA_D = 32'h0000000A; step();
      b3.regA_D = 32'h0000000B; step();
      b3.regA_D = 32'h0000000C; step();
      check("st_pre_regA", b3.regA_E, 32'h0000000A);
      b3.stall_E = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         b3.ALUope_D = k[0];
         b3.regA_D   = 32'hDEAD0000 + 32'(k);
         step();
         check("st_hold_regA",  b3.regA_E,    32'h0000000A);
         check("st_hold_aluop", b3.ALUope_E,  1'b1);
         check("st_cnt",        b3.stall_cnt, 16'(k));
      end
      b3.stall_E = 1'b0; b3.valid_D = 1'b0;
      step();
      check("st_rel_B", b3.regA_E, 32'h0000000B);
      step();
      check("st_rel_C", b3.regA_E, 32'h0000000C);
      step();
      check("st_rel_empty", b3.valid_E, 1'b0);

      // ---- stall and flush together: flush wins ----
      b3.valid_D = 1'b1; b3.regA_D = 32'h0000000E; step();
      b3.valid_D = 1'b0; b3.stall_E = 1'b1; b3.flush_E = 1'b1; step();
      b3.stall_E = 1'b0; b3.flush_E = 1'b0;
      check("sf_scnt", b3.stall_cnt, 16'd5);
      check("sf_fcnt", b3.flush_cnt, 16'd4);
      step(); step();
      check("sf_gone", b3.valid_E, 1'b0);

      // ---- asynchronous reset mid-stall with data in flight ----
      b3.valid_D = 1'b1;
      b3.regA_D = 32'h000000F1; step();
      b3.regA_D = 32'h000000F2; step();
      b3.regA_D = 32'h000000F3; step();
      check("ar_pre", b3.regA_E, 32'h000000F1);
      b3.stall_E = 1'b1; step();
      #3 rst = 1'b0;
      #1;
      check("ar_valid", b3.valid_E,   1'b0);
      check("ar_regA",  b3.regA_E,    32'h0);
      check("ar_regw",  b3.regw_E,    1'b0);
      check("ar_scnt",  b3.stall_cnt, 16'h0);
      check("ar_fcnt",  b3.flush_cnt, 16'h0);
      b3.stall_E = 1'b0; b3.regA_D = 32'h00000077;
      #2 rst = 1'b1;
      step();
      b3.valid_D = 1'b0;
      check("ar_post1", b3.valid_E, 1'b0);
      step();
      check("ar_post2", b3.valid_E, 1'b0);
      step();
      check("ar_post3_valid", b3.valid_E, 1'b1);
      check("ar_post3_regA",  b3.regA_E,  32'h00000077);

      // ---- counter saturation (STAGES=1) ----
      b1.valid_D = 1'b1; step();
      force dut1.flush_cnt_q = 16'hFFFE;
      #1 release dut1.flush_cnt_q;
      b1.valid_D = 1'b0; b1.flush_E = 1'b1; step();
      check("sat_f1", b1.flush_cnt, 16'hFFFF);
      b1.flush_E = 1'b0; b1.valid_D = 1'b1; step();
      b1.valid_D = 1'b0; b1.flush_E = 1'b1; step();
      check("sat_f2", b1.flush_cnt, 16'hFFFF);
      b1.flush_E = 1'b0;
      force dut1.stall_cnt_q = 16'hFFFE;
      #1 release dut1.stall_cnt_q;
      b1.stall_E = 1'b1; step();
      check("sat_s1", b1.stall_cnt, 16'hFFFF);
      step();
      check("sat_s2", b1.stall_cnt, 16'hFFFF);
      b1.stall_E = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
